pipe_ctrl: RTL and testbench
============================

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter EXC_VECTOR, default 32'hBFC00380, exception entry PC.
REQ-002 Parameter TIMEOUT, default 16'd1023, consecutive-stall watchdog threshold.
REQ-003 clk  in  1  clock; all state updates on posedge clk.
REQ-004 reset  in  1  reset, synchronous, active-high.
REQ-005 stallreq_if  in  1  fetch-stage stall request (icache miss).
REQ-006 stallreq_id  in  1  decode-stage stall request (load-use).
REQ-007 stallreq_ex  in  1  execute-stage stall request (multi-cycle mul/div).
REQ-008 stallreq_mem  in  1  memory-stage stall request (dcache miss).
REQ-009 mem_except  in  7  exception code from the EX/MEM register; nonzero = exception.
REQ-010 mem_eret  in  1  ERET from the EX/MEM register.
REQ-011 cp0_epc  in  32  current EPC.
REQ-012 stall  out  6  per-stage hold: [0] PC, [1] IF/ID, [2] ID/EX, [3] EX/MEM, [4] MEM/WB, [5] WB; 1 = Stop.
REQ-013 flush  out  1  registered, clears all pipeline registers.
REQ-014 new_pc  out  32  redirect target, valid while flush=1.
REQ-015 stall_timeout  out  1  sticky watchdog flag.
REQ-016 stall_cycles  out  32  count of cycles with stall!=0.

Function
REQ-017 FSM states: RUN, FREEZE, FLUSH, RECOVER.
REQ-018 RUN, no event: stall is combinational, highest active request wins: mem -> 6'b011111, ex -> 6'b001111, id -> 6'b000111, if -> 6'b000011, none -> 6'b000000.
REQ-019 Event = (mem_except!=0 or mem_eret) with stallreq_mem=0; in RUN it moves FSM to FREEZE next cycle, latches target (eret -> cp0_epc, else EXC_VECTOR); eret has priority when both are set.
REQ-020 Event with stallreq_mem=1: stallreq_mem wins; FSM stays RUN, stall=6'b011111; event taken in the first cycle stallreq_mem=0.
REQ-021 FREEZE: stall=6'b111111, flush=0; next state FLUSH unconditionally.
REQ-022 FLUSH: flush=1 exactly one cycle, new_pc=latched target, stall=6'b000000; next state RECOVER.
REQ-023 RECOVER: stall=6'b000000, flush=0, all stall requests and events ignored; next state RUN.
REQ-024 new_pc holds its last value outside FLUSH.
REQ-025 stall_cnt (16 bit) increments each cycle stall!=0 and saturates at 16'hFFFF; cleared by any cycle with stall==0.
REQ-026 stall_timeout sets when stall_cnt==TIMEOUT and holds until reset.
REQ-027 stall_cycles increments each cycle stall!=0, wraps 32'hFFFFFFFF -> 0.
REQ-028 Latency: event sampled in cycle N gives FREEZE in N+1, flush in N+2, RUN in N+4.

Reset
REQ-029 reset SHALL force state=RUN, stall=6'b000000, flush=0, new_pc=0, stall_cnt=0, stall_timeout=0, stall_cycles=0, latched target=0.
REQ-030 reset in any state, including FLUSH, SHALL abort the sequence; no flush SHALL be driven in the cycle after reset.
REQ-031 reset SHALL override all simultaneous inputs.

Structure
REQ-032 Stall encodings, state codes, Stop/NoStop and EXC_VECTOR default SHALL live in the shared global define header.
REQ-033 One sub-module, stall_watchdog (stall_cnt, stall_timeout, stall_cycles), SHALL be instantiated; the FSM and encoder stay in pipe_ctrl.

Verification
REQ-034 stallreq_id=1 and stallreq_ex=1 in RUN -> stall=6'b001111 same cycle; stall_cycles +1.
REQ-035 mem_except=7'h04 in RUN, no stalls -> N+1 stall=6'b111111; N+2 flush=1, new_pc=32'hBFC00380; N+3 stall=0; N+4 RUN.
REQ-036 mem_eret=1 with cp0_epc=32'h80001234 while stallreq_mem=1 for 3 cycles -> stall=6'b011111 for 3 cycles, then the FREEZE/FLUSH sequence with new_pc=32'h80001234.
REQ-037 reset asserted during FLUSH -> next cycle flush=0, stall=0, state RUN, counters 0.
REQ-038 stallreq_mem held 1023 cycles, TIMEOUT=1023 -> stall_timeout=1 and stays 1 after the request drops; stall_cnt clears.
REQ-039 Event in RECOVER -> ignored; event still present in RUN -> sequence starts the next cycle.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline controller: state codes, stall encodings
// and default parameter values.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_FREEZE  = 2'd1,
        ST_FLUSH   = 2'd2,
        ST_RECOVER = 2'd3
    } state_e;

    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    // Bit order: [0] PC, [1] IF/ID, [2] ID/EX, [3] EX/MEM, [4] MEM/WB, [5] WB
    localparam logic [5:0] STALL_NONE = {6{NO_STOP}};
    localparam logic [5:0] STALL_IF   = 6'b000011;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_EX   = 6'b001111;
    localparam logic [5:0] STALL_MEM  = 6'b011111;
    localparam logic [5:0] STALL_ALL  = {6{STOP}};

    localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'hBFC00380;
    localparam logic [15:0] TIMEOUT_DEFAULT    = 16'd1023;

    function automatic logic [5:0] stall_encode(input logic req_if, input logic req_id,
                                                input logic req_ex, input logic req_mem);
        if (req_mem)     return STALL_MEM;
        else if (req_ex) return STALL_EX;
        else if (req_id) return STALL_ID;
        else if (req_if) return STALL_IF;
        else             return STALL_NONE;
    endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Pipeline-to-controller bundle: stage stall requests and exception info in,
// per-stage hold, flush/redirect and watchdog status out.
interface pipe_ctrl_if;
    logic        stallreq_if;
    logic        stallreq_id;
    logic        stallreq_ex;
    logic        stallreq_mem;
    logic [6:0]  mem_except;
    logic        mem_eret;
    logic [31:0] cp0_epc;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        stall_timeout;
    logic [31:0] stall_cycles;

    modport master (
        output stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
        output mem_except, mem_eret, cp0_epc,
        input  stall, flush, new_pc, stall_timeout, stall_cycles
    );

    modport slave (
        input  stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
        input  mem_except, mem_eret, cp0_epc,
        output stall, flush, new_pc, stall_timeout, stall_cycles
    );
endinterface

// File: rtl/pipe_ctrl_stall_watchdog.sv
// Stall watchdog: consecutive-stall counter with sticky timeout flag and a
// free-running count of stalled cycles.
module stall_watchdog
    import pipe_ctrl_pkg::*;
#(
    parameter logic [15:0] TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  stall,
    output logic        stall_timeout,
    output logic [31:0] stall_cycles
);

    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic        stall_timeout_q, stall_timeout_d;
    logic [31:0] stall_cycles_q, stall_cycles_d;
    logic        stalled;

    always_comb begin
        stalled        = (stall != STALL_NONE);
        stall_cnt_d    = 16'd0;
        stall_cycles_d = stall_cycles_q;
        if (stalled) begin
            stall_cnt_d    = (stall_cnt_q == 16'hFFFF) ? stall_cnt_q : stall_cnt_q + 16'd1;
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
        // Flag rises on the same edge the counter reaches the threshold.
        stall_timeout_d = stall_timeout_q | (stall_cnt_d == TIMEOUT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q     <= 16'd0;
            stall_timeout_q <= 1'b0;
            stall_cycles_q  <= 32'd0;
        end else begin
            stall_cnt_q     <= stall_cnt_d;
            stall_timeout_q <= stall_timeout_d;
            stall_cycles_q  <= stall_cycles_d;
        end
    end

    assign stall_timeout = stall_timeout_q;
    assign stall_cycles  = stall_cycles_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard/exception controller: stall priority encoder plus the
// freeze -> flush -> recover redirect sequence.
//   state      | meaning
//   ST_RUN     | normal flow, stall follows highest-priority request
//   ST_FREEZE  | event accepted, every stage held
//   ST_FLUSH   | one-cycle flush, new_pc carries the redirect target
//   ST_RECOVER | one quiet cycle, requests and events ignored
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEFAULT,
    parameter logic [15:0] TIMEOUT    = TIMEOUT_DEFAULT
) (
    input  logic     clk,
    input  logic     reset,
    pipe_ctrl_if.slave bus
);

    state_e      state_q, state_d;
    logic [31:0] target_q, target_d;
    logic [31:0] new_pc_q, new_pc_d;
    logic        flush_q, flush_d;
    logic [5:0]  stall_req;
    logic [5:0]  stall_o;
    logic        event_hit;
    logic        wd_timeout;
    logic [31:0] wd_cycles;

    always_comb begin
        // A dcache miss outranks the event; it is taken once the miss clears.
        event_hit = ((bus.mem_except != 7'd0) || bus.mem_eret) && !bus.stallreq_mem;
        stall_req = stall_encode(bus.stallreq_if, bus.stallreq_id,
                                 bus.stallreq_ex, bus.stallreq_mem);
        state_d   = state_q;
        target_d  = target_q;
        stall_o   = STALL_NONE;
        case (state_q)
            ST_RUN: begin
                stall_o = stall_req;
                if (event_hit) begin
                    state_d  = ST_FREEZE;
                    target_d = bus.mem_eret ? bus.cp0_epc : EXC_VECTOR;
                end
            end
            ST_FREEZE: begin
                stall_o = STALL_ALL;
                state_d = ST_FLUSH;
            end
            ST_FLUSH:   state_d = ST_RECOVER;
            ST_RECOVER: state_d = ST_RUN;
            default:    state_d = ST_RUN;
        endcase
        if (reset) stall_o = STALL_NONE;
        flush_d  = (state_d == ST_FLUSH);
        new_pc_d = flush_d ? target_d : new_pc_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_RUN;
            target_q <= 32'd0;
            new_pc_q <= 32'd0;
            flush_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            new_pc_q <= new_pc_d;
            flush_q  <= flush_d;
        end
    end

    stall_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall_o),
        .stall_timeout (wd_timeout),
        .stall_cycles  (wd_cycles)
    );

    assign bus.stall         = stall_o;
    assign bus.flush         = flush_q;
    assign bus.new_pc        = new_pc_q;
    assign bus.stall_timeout = wd_timeout;
    assign bus.stall_cycles  = wd_cycles;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: cycle table of inputs/expected outputs checked through a
// scoreboard queue, plus reset-abort and watchdog sequences.
module tb_pipe_ctrl;

    logic clk;
    logic reset;

    pipe_ctrl_if bus();

    pipe_ctrl #(.EXC_VECTOR(32'hBFC00380), .TIMEOUT(16'd1023)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  req;      // {mem, ex, id, if}
        logic [6:0]  exc;
        logic        eret;
        logic [31:0] epc;
        logic [5:0]  e_stall;
        logic        e_flush;
        logic [31:0] e_pc;
    } vec_t;

    typedef struct {
        logic [5:0]  stall;
        logic        flush;
        logic [31:0] pc;
        logic [31:0] cycles;
        logic        timeout;
    } exp_t;

    vec_t        vecs[$];
    exp_t        sb[$];
    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] cyc_model = 32'd0;
    logic        exp_to = 1'b0;

    function automatic vec_t mk(input logic [3:0] req, input logic [6:0] exc, input logic eret,
                                input logic [31:0] epc, input logic [5:0] e_stall,
                                input logic e_flush, input logic [31:0] e_pc);
        vec_t v;
        v.req = req; v.exc = exc; v.eret = eret; v.epc = epc;
        v.e_stall = e_stall; v.e_flush = e_flush; v.e_pc = e_pc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [3:0] req, input logic [6:0] exc, input logic eret,
                         input logic [31:0] epc);
        bus.stallreq_mem = req[3];
        bus.stallreq_ex  = req[2];
        bus.stallreq_id  = req[1];
        bus.stallreq_if  = req[0];
        bus.mem_except   = exc;
        bus.mem_eret     = eret;
        bus.cp0_epc      = epc;
    endtask

    // Push the outputs expected for the current cycle and advance the cycle model.
    task automatic expect_out(input logic [5:0] st, input logic fl, input logic [31:0] pc);
        exp_t e;
        e.stall = st; e.flush = fl; e.pc = pc; e.cycles = cyc_model; e.timeout = exp_to;
        sb.push_back(e);
        if (st != 6'd0) cyc_model = cyc_model + 32'd1;
    endtask

    task automatic check_cycle(input string tag);
        exp_t e;
        @(negedge clk);
        if (sb.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s scoreboard: got empty queue, expected an entry", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, " stall"},   {26'd0, bus.stall}, {26'd0, e.stall});
            chk({tag, " flush"},   {31'd0, bus.flush}, {31'd0, e.flush});
            chk({tag, " new_pc"},  bus.new_pc, e.pc);
            chk({tag, " cycles"},  bus.stall_cycles, e.cycles);
            chk({tag, " timeout"}, {31'd0, bus.stall_timeout}, {31'd0, e.timeout});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_cycle(input string tag, input logic [3:0] req, input logic [6:0] exc,
                             input logic eret, input logic [31:0] epc,
                             input logic [5:0] st, input logic fl, input logic [31:0] pc);
        drive(req, exc, eret, epc);
        expect_out(st, fl, pc);
        check_cycle(tag);
    endtask

    localparam logic [31:0] EXC = 32'hBFC00380;
    localparam logic [31:0] EPC1 = 32'h80001234;
    localparam logic [31:0] EPC2 = 32'h80005678;

    initial begin
        // RUN encoder patterns
        vecs.push_back(mk(4'b0000, 7'h00, 0, 0, 6'b000000, 0, 0));
        vecs.push_back(mk(4'b0001, 7'h00, 0, 0, 6'b000011, 0, 0));
        vecs.push_back(mk(4'b0010, 7'h00, 0, 0, 6'b000111, 0, 0));
        vecs.push_back(mk(4'b0100, 7'h00, 0, 0, 6'b001111, 0, 0));
        vecs.push_back(mk(4'b0110, 7'h00, 0, 0, 6'b001111, 0, 0));
        vecs.push_back(mk(4'b1001, 7'h00, 0, 0, 6'b011111, 0, 0));
        vecs.push_back(mk(4'b1111, 7'h00, 0, 0, 6'b011111, 0, 0));
        vecs.push_back(mk(4'b0000, 7'h00, 0, 0, 6'b000000, 0, 0));
        // exception -> FREEZE/FLUSH/RECOVER/RUN
        vecs.push_back(mk(4'b0000, 7'h04, 0, 0, 6'b000000, 0, 0));
        vecs.push_back(mk(4'b0000, 7'h00, 0, 0, 6'b111111, 0, 0));
        vecs.push_back(mk(4'b0000, 7'h00, 0, 0, 6'b000000, 1, EXC));
        vecs.push_back(mk(4'b1111, 7'h04, 1, 32'h11112222, 6'b000000, 0, EXC));
        vecs.push_back(mk(4'b0000, 7'h00, 0, 0, 6'b000000, 0, EXC));
        // eret deferred behind dcache miss
        vecs.push_back(mk(4'b1000, 7'h00, 1, EPC1, 6'b011111, 0, EXC));
        vecs.push_back(mk(4'b1000, 7'h00, 1, EPC1, 6'b011111, 0, EXC));
        vecs.push_back(mk(4'b1000, 7'h00, 1, EPC1, 6'b011111, 0, EXC));
        vecs.push_back(mk(4'b0000, 7'h00, 1, EPC1, 6'b000000, 0, EXC));
        vecs.push_back(mk(4'b0000, 7'h00, 0, 0, 6'b111111, 0, EXC));
        vecs.push_back(mk(4'b0000, 7'h00, 0, 0, 6'b000000, 1, EPC1));
        vecs.push_back(mk(4'b0000, 7'h00, 0, 0, 6'b000000, 0, EPC1));
        vecs.push_back(mk(4'b0000, 7'h00, 0, 0, 6'b000000, 0, EPC1));
        // eret wins over simultaneous exception code
        vecs.push_back(mk(4'b0000, 7'h0C, 1, EPC2, 6'b000000, 0, EPC1));
        vecs.push_back(mk(4'b0000, 7'h00, 0, 0, 6'b111111, 0, EPC1));
        vecs.push_back(mk(4'b0000, 7'h00, 0, 0, 6'b000000, 1, EPC2));
        // event in RECOVER ignored, taken once back in RUN
        vecs.push_back(mk(4'b0000, 7'h04, 0, 0, 6'b000000, 0, EPC2));
        vecs.push_back(mk(4'b0000, 7'h04, 0, 0, 6'b000000, 0, EPC2));
        vecs.push_back(mk(4'b0000, 7'h00, 0, 0, 6'b111111, 0, EPC2));
        vecs.push_back(mk(4'b0000, 7'h00, 0, 0, 6'b000000, 1, EXC));
        vecs.push_back(mk(4'b0000, 7'h00, 0, 0, 6'b000000, 0, EXC));
        vecs.push_back(mk(4'b0000, 7'h00, 0, 0, 6'b000000, 0, EXC));
        // event alongside an ex stall; requests ignored in FREEZE and RECOVER
        vecs.push_back(mk(4'b0100, 7'h04, 0, 0, 6'b001111, 0, EXC));
        vecs.push_back(mk(4'b1111, 7'h00, 0, 0, 6'b111111, 0, EXC));
        vecs.push_back(mk(4'b0000, 7'h00, 0, 0, 6'b000000, 1, EXC));
        vecs.push_back(mk(4'b0100, 7'h00, 0, 0, 6'b000000, 0, EXC));
        vecs.push_back(mk(4'b0100, 7'h00, 0, 0, 6'b001111, 0, EXC));

        // Reset with active requests: outputs stay quiet
        reset = 1'b1;
        drive(4'b1000, 7'h04, 1'b1, EPC1);
        @(posedge clk);
        @(posedge clk);
        #1;
        expect_out(6'b000000, 1'b0, 32'd0);
        check_cycle("reset");
        reset = 1'b0;

        foreach (vecs[i]) begin
            run_cycle($sformatf("vec%0d", i), vecs[i].req, vecs[i].exc, vecs[i].eret,
                      vecs[i].epc, vecs[i].e_stall, vecs[i].e_flush, vecs[i].e_pc);
        end

        // Reset arriving during FLUSH aborts the sequence
        run_cycle("abort_ev",     4'b0000, 7'h04, 0, 0, 6'b000000, 0, EXC);
        run_cycle("abort_freeze", 4'b0000, 7'h00, 0, 0, 6'b111111, 0, EXC);
        reset = 1'b1;
        drive(4'b1000, 7'h00, 1'b1, EPC1);
        expect_out(6'b000000, 1'b1, EXC);
        cyc_model = 32'd0;
        check_cycle("abort_rst");
        reset = 1'b0;
        run_cycle("abort_post0", 4'b0000, 7'h00, 0, 0, 6'b000000, 0, 32'd0);
        run_cycle("abort_post1", 4'b0000, 7'h00, 0, 0, 6'b000000, 0, 32'd0);
        run_cycle("abort_run",   4'b1000, 7'h00, 0, 0, 6'b011111, 0, 32'd0);
        run_cycle("wd_idle",     4'b0000, 7'h00, 0, 0, 6'b000000, 0, 32'd0);

        // Watchdog: 1023 consecutive dcache-miss cycles
        for (int i = 0; i < 1023; i++) begin
            run_cycle("wd_hold", 4'b1000, 7'h00, 0, 0, 6'b011111, 0, 32'd0);
        end
        exp_to = 1'b1;
        drive(4'b0000, 7'h00, 0, 0);
        expect_out(6'b000000, 1'b0, 32'd0);
        @(negedge clk);
        chk("wd_cnt_at_thresh", {16'd0, dut.u_watchdog.stall_cnt_q}, 32'd1023);
        check_cycle("wd_drop");
        drive(4'b0000, 7'h00, 0, 0);
        expect_out(6'b000000, 1'b0, 32'd0);
        @(negedge clk);
        chk("wd_cnt_cleared", {16'd0, dut.u_watchdog.stall_cnt_q}, 32'd0);
        check_cycle("wd_sticky0");
        run_cycle("wd_sticky1", 4'b0001, 7'h00, 0, 0, 6'b000011, 0, 32'd0);
        run_cycle("wd_sticky2", 4'b0000, 7'h00, 0, 0, 6'b000000, 0, 32'd0);

        chk("sb_drained", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout: got no finish, expected finish before 200000");
        $fatal(1, "bench time limit");
    end

endmodule
